alu_issue_ctrl: RTL

Command-side initiator for the combinational 32-bit ALU. It accepts compact 4-bit opcodes with operands on a valid/ready interface and decodes each into the ALU's 6-bit function code. It drives the external ALU instance from a registered issue stage, captures the ALU result, and returns results in order through a 2-entry buffered valid/ready interface with a tag and an illegal-opcode error flag.

---
 rtl/alu_pkg.sv | 64 ++++++
 rtl/alu_res_fifo.sv | 53 +++++
 rtl/alu_issue_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller.
//   op_e       : compact 4-bit command opcodes (0x0..0xB legal, 0xC..0xF illegal)
//   FN_*       : 6-bit ALU function codes; fn[5:4] selects cmp/arith/bool/shift
//   dec_t      : decoded {fn, illegal} pair
//   op_decode  : opcode -> dec_t; illegal opcodes issue as ADD with the flag set
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_MOVA  = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_SRA   = 4'h8,
    OP_CMPEQ = 4'h9,
    OP_CMPLT = 4'hA,
    OP_CMPLE = 4'hB
  } op_e;

  // Bool group: fn[3:0] is the truth table indexed by {b,a}.
  localparam logic [5:0] FN_ADD   = 6'b010000;
  localparam logic [5:0] FN_SUB   = 6'b010001;
  localparam logic [5:0] FN_AND   = 6'b101000;
  localparam logic [5:0] FN_OR    = 6'b101110;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_MOVA  = 6'b101010;
  localparam logic [5:0] FN_SHL   = 6'b110000;
  localparam logic [5:0] FN_SHR   = 6'b110001;
  localparam logic [5:0] FN_SRA   = 6'b110011;
  localparam logic [5:0] FN_CMPEQ = 6'b000010;
  localparam logic [5:0] FN_CMPLT = 6'b000100;
  localparam logic [5:0] FN_CMPLE = 6'b000110;

  typedef struct packed {
    logic [5:0] fn;
    logic       illegal;
  } dec_t;

  function automatic dec_t op_decode(input logic [3:0] op);
    dec_t d;
    d.fn      = FN_ADD;
    d.illegal = 1'b0;
    case (op_e'(op))
      OP_ADD:   d.fn = FN_ADD;
      OP_SUB:   d.fn = FN_SUB;
      OP_AND:   d.fn = FN_AND;
      OP_OR:    d.fn = FN_OR;
      OP_XOR:   d.fn = FN_XOR;
      OP_MOVA:  d.fn = FN_MOVA;
      OP_SHL:   d.fn = FN_SHL;
      OP_SHR:   d.fn = FN_SHR;
      OP_SRA:   d.fn = FN_SRA;
      OP_CMPEQ: d.fn = FN_CMPEQ;
      OP_CMPLT: d.fn = FN_CMPLT;
      OP_CMPLE: d.fn = FN_CMPLE;
      default:  d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// 2-entry synchronous result FIFO with a registered head.
//   clk, rst_n : clock, async active-low reset (entries cleared to 0)
//   push/wdata : write one entry (caller guarantees count<2 or a same-cycle pop)
//   pop        : drop the head (caller guarantees count>0)
//   head       : entry 0, straight from a register
//   count      : occupancy 0..2
module alu_res_fifo #(
  parameter int DATA_W = 37
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  // mem[0] is always the head, so the output needs no read mux.
  logic [1:0][DATA_W-1:0] mem;

  assign head = mem[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) mem[0] <= wdata;
          else               mem[1] <= wdata;
          count <= count + 2'd1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; with 2 entries the tail slides into the head.
          if (count == 2'd1) begin
            mem[0] <= wdata;
          end else begin
            mem[0] <= mem[1];
            mem[1] <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command-side initiator for the external combinational ALU.
//   in_*   : valid/ready command port (4-bit opcode, operands, tag)
//   alu_*  : registered drive to the ALU, alu_out is its combinational result
//   out_*  : in-order valid/ready result port with tag and illegal-op flag
//   err_count : saturating count of accepted illegal opcodes
// One issue stage (S1) feeds the ALU; its result is captured into a 2-entry FIFO.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int TAG_W    = 4,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [5:0]          alu_fn,
  input  logic [WIDTH-1:0]    alu_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int ENT_W = 1 + TAG_W + WIDTH;

  dec_t             dec;
  logic             s1_valid;
  logic             s1_illegal;
  logic [TAG_W-1:0] s1_tag;
  logic             accept;
  logic             push;
  logic             pop;
  logic             push_ok;
  logic [1:0]       fifo_count;
  logic [ENT_W-1:0] wdata;
  logic [ENT_W-1:0] head;

  assign dec = op_decode(in_op);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push
  // when the consumer is draining; this is the out_ready -> in_ready path.
  assign pop      = out_valid && out_ready;
  assign push_ok  = (fifo_count < 2'd2) || pop;
  assign push     = s1_valid && push_ok;
  assign in_ready = !s1_valid || push_ok;
  assign accept   = in_valid && in_ready;

  assign wdata = {s1_illegal, s1_tag, s1_illegal ? {WIDTH{1'b0}} : alu_out};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_illegal <= 1'b0;
      s1_tag     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fn     <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_illegal <= dec.illegal;
      s1_tag     <= in_tag;
      alu_a      <= in_a;
      alu_b      <= in_b;
      alu_fn     <= dec.fn;
    end else if (push) begin
      // ALU operands are left as-is; only the stage is freed.
      s1_valid   <= 1'b0;
    end
  end

  // Counted at accept so the count tracks commands the caller issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (accept && dec.illegal && (err_count != {ERRCNT_W{1'b1}}))
      err_count <= err_count + ERRCNT_W'(1);
  end

  alu_res_fifo #(.DATA_W(ENT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .head  (head),
    .count (fifo_count)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign {out_err, out_tag, out_result} = head;

endmodule
